// File: rtl/mccpu_hs_pkg.sv
// Shared definitions for the mccpu_hs multicycle core: opcodes, functs,
// FSM states, ALU operations and small decode helpers.
package mccpu_hs_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_EXEC_I = 4'd3,
    ST_MEMADR = 4'd4,
    ST_MEMRD  = 4'd5,
    ST_MEMWB  = 4'd6,
    ST_MEMWR  = 4'd7,
    ST_REGWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_HALT   = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_LUI = 3'd7
  } alu_op_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    sext16 = {{16{v[15]}}, v};
  endfunction

  function automatic alu_op_e funct_alu(input logic [5:0] fn);
    case (fn)
      FN_SUBU: funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      FN_SLL:  funct_alu = ALU_SLL;
      FN_SRL:  funct_alu = ALU_SRL;
      default: funct_alu = ALU_ADD;
    endcase
  endfunction

  function automatic alu_op_e opcode_alu(input logic [5:0] op);
    case (op)
      OP_ANDI: opcode_alu = ALU_AND;
      OP_ORI:  opcode_alu = ALU_OR;
      OP_LUI:  opcode_alu = ALU_LUI;
      default: opcode_alu = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mccpu_hs_alu.sv
// Combinational 32-bit ALU for mccpu_hs; shifts act on operand b by shamt,
// lui places the low half of b in the upper half of the result.
module mccpu_hs_alu
  import mccpu_hs_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        zero
);

  // Operation select.
  always_comb begin
    result = 32'h0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'h0, ($signed(a) < $signed(b))};
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      ALU_LUI: result = {b[15:0], 16'h0};
      default: result = a + b;
    endcase
  end

  assign zero = (result == 32'h0);

endmodule

// File: rtl/mccpu_hs.sv
// Multicycle MIPS-subset core with a stall-capable unified ready/valid memory
// port, parametrised reset vector and optional trap-to-halt on illegal ops.
module mccpu_hs
  import mccpu_hs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter bit          TRAP_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] instr,
  output logic [31:0] PC,
  output logic        halted,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);

  localparam state_e ILLEGAL_DEST = TRAP_EN ? ST_HALT : ST_FETCH;

  state_e      state_r, next_state_s, dispatch_s;
  logic [31:0] pc_r, ir_r, a_r, b_r, aluout_r, mdr_r;
  logic        halted_r;
  logic [31:0] rf_r [32];

  logic [5:0]  opcode_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
  logic [31:0] sext_imm_s, zext_imm_s, jump_target_s;
  logic [31:0] alu_a_s, alu_b_s, alu_y_s;
  alu_op_e     alu_op_s;
  logic        alu_zero_s, take_s, misaligned_s;
  logic        rf_we_s, rf_wr_en_s;
  logic [4:0]  rf_waddr_s;
  logic [31:0] rf_wdata_s;
  logic        mem_req_s, mem_we_s;
  logic [31:0] mem_addr_s;

  assign opcode_s   = ir_r[31:26];
  assign rs_s       = ir_r[25:21];
  assign rt_s       = ir_r[20:16];
  assign rd_s       = ir_r[15:11];
  assign shamt_s    = ir_r[10:6];
  assign funct_s    = ir_r[5:0];
  assign sext_imm_s = sext16(ir_r[15:0]);
  assign zext_imm_s = {16'h0, ir_r[15:0]};

  // jr shares the JUMP state with j/jal; only the target differs.
  assign jump_target_s = (opcode_s == OP_RTYPE) ? a_r : {pc_r[31:28], ir_r[25:0], 2'b00};
  assign take_s        = (opcode_s == OP_BNE) ? ~alu_zero_s : alu_zero_s;
  assign misaligned_s  = (alu_y_s[1:0] != 2'b00);

  mccpu_hs_alu u_alu (
    .op     (alu_op_s),
    .a      (alu_a_s),
    .b      (alu_b_s),
    .shamt  (shamt_s),
    .result (alu_y_s),
    .zero   (alu_zero_s)
  );

  // ALU operand steering; FETCH uses the default PC+4.
  always_comb begin
    alu_a_s  = pc_r;
    alu_b_s  = 32'd4;
    alu_op_s = ALU_ADD;
    case (state_r)
      ST_DECODE: alu_b_s = {sext_imm_s[29:0], 2'b00};
      ST_EXEC_R: begin
        alu_a_s  = a_r;
        alu_b_s  = b_r;
        alu_op_s = funct_alu(funct_s);
      end
      ST_EXEC_I: begin
        alu_a_s  = a_r;
        alu_b_s  = (opcode_s == OP_ADDIU) ? sext_imm_s : zext_imm_s;
        alu_op_s = opcode_alu(opcode_s);
      end
      ST_MEMADR: begin
        alu_a_s = a_r;
        alu_b_s = sext_imm_s;
      end
      ST_BRANCH: begin
        alu_a_s  = a_r;
        alu_b_s  = b_r;
        alu_op_s = ALU_SUB;
      end
      default: alu_op_s = ALU_ADD;
    endcase
  end

  // Instruction dispatch out of DECODE.
  always_comb begin
    dispatch_s = ILLEGAL_DEST;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_JR:                                          dispatch_s = ST_JUMP;
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT,
          FN_SLL, FN_SRL:                                 dispatch_s = ST_EXEC_R;
          default:                                        dispatch_s = ILLEGAL_DEST;
        endcase
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: dispatch_s = ST_EXEC_I;
      OP_LW, OP_SW:                      dispatch_s = ST_MEMADR;
      OP_BEQ, OP_BNE:                    dispatch_s = ST_BRANCH;
      OP_J, OP_JAL:                      dispatch_s = ST_JUMP;
      default:                           dispatch_s = ILLEGAL_DEST;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; memory states wait for mem_ready.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_FETCH:  next_state_s = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: next_state_s = dispatch_s;
      ST_EXEC_R: next_state_s = ST_REGWB;
      ST_EXEC_I: next_state_s = ST_REGWB;
      ST_MEMADR: begin
        if (misaligned_s) begin
          next_state_s = ILLEGAL_DEST;
        end else if (opcode_s == OP_LW) begin
          next_state_s = ST_MEMRD;
        end else begin
          next_state_s = ST_MEMWR;
        end
      end
      ST_MEMRD:  next_state_s = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  next_state_s = ST_FETCH;
      ST_MEMWR:  next_state_s = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_REGWB:  next_state_s = ST_FETCH;
      ST_BRANCH: next_state_s = ST_FETCH;
      ST_JUMP:   next_state_s = ST_FETCH;
      ST_HALT:   next_state_s = ST_HALT;
      default:   next_state_s = ST_HALT;
    endcase
  end

  // FSM outputs: memory request decoded from state, address from PC or ALUOut.
  always_comb begin
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    mem_addr_s = pc_r;
    case (state_r)
      ST_FETCH: mem_req_s = 1'b1;
      ST_MEMRD: begin
        mem_req_s  = 1'b1;
        mem_addr_s = aluout_r;
      end
      ST_MEMWR: begin
        mem_req_s  = 1'b1;
        mem_we_s   = 1'b1;
        mem_addr_s = aluout_r;
      end
      default: mem_req_s = 1'b0;
    endcase
  end

  // Datapath registers; stalled memory states leave everything untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r     <= RESET_PC;
      ir_r     <= 32'h0;
      a_r      <= 32'h0;
      b_r      <= 32'h0;
      aluout_r <= 32'h0;
      mdr_r    <= 32'h0;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (mem_ready) begin
            ir_r <= mem_rdata;
            pc_r <= alu_y_s;
          end
        end
        ST_DECODE: begin
          a_r      <= rf_r[rs_s];
          b_r      <= rf_r[rt_s];
          aluout_r <= alu_y_s;
        end
        ST_EXEC_R, ST_EXEC_I, ST_MEMADR: aluout_r <= alu_y_s;
        ST_MEMRD: begin
          if (mem_ready) begin
            mdr_r <= mem_rdata;
          end
        end
        ST_BRANCH: begin
          if (take_s) begin
            pc_r <= aluout_r;
          end
        end
        ST_JUMP: pc_r <= jump_target_s;
        default: ;
      endcase
      if (next_state_s == ST_HALT) begin
        halted_r <= 1'b1;
      end
    end
  end

  // Register-file write port selection; jal links the already-incremented PC.
  always_comb begin
    rf_we_s    = 1'b0;
    rf_waddr_s = rt_s;
    rf_wdata_s = aluout_r;
    case (state_r)
      ST_REGWB: begin
        rf_we_s    = 1'b1;
        rf_waddr_s = (opcode_s == OP_RTYPE) ? rd_s : rt_s;
      end
      ST_MEMWB: begin
        rf_we_s    = 1'b1;
        rf_wdata_s = mdr_r;
      end
      ST_JUMP: begin
        if (opcode_s == OP_JAL) begin
          rf_we_s    = 1'b1;
          rf_waddr_s = 5'd31;
          rf_wdata_s = pc_r;
        end else begin
          rf_we_s = 1'b0;
        end
      end
      default: rf_we_s = 1'b0;
    endcase
  end

  assign rf_wr_en_s = rf_we_s && (rf_waddr_s != 5'd0);

  // Register file storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_r[i] <= 32'h0;
      end
    end else if (rf_wr_en_s) begin
      rf_r[rf_waddr_s] <= rf_wdata_s;
    end
  end

  assign mem_req   = mem_req_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = b_r;
  assign instr     = ir_r;
  assign PC        = pc_r;
  assign halted    = halted_r;
  assign reg_data  = (reg_sel == 5'd0) ? 32'h0 : rf_r[reg_sel];

endmodule
